// File: rtl/blink_monitor_pkg.sv
// Shared state encoding and default timing constants for the blink monitor.
package blink_monitor_pkg;

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED, FAULT} state_t;

  localparam int DEF_HALF_PERIOD = 10;
  localparam int DEF_TOLERANCE   = 0;
  localparam int DEF_LOCK_COUNT  = 4;

endpackage

// File: rtl/blink_sync.sv
// Two-flop synchronizer bringing the monitored blink line into the clock domain.
module blink_sync (
  input  logic clock,
  input  logic reset_n,
  input  logic raw,
  output logic synced
);

  logic meta;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta   <= 1'b0;
      synced <= 1'b0;
    end else begin
      meta   <= raw;
      synced <= meta;
    end
  end

endmodule

// File: rtl/blink_monitor.sv
// Measures every high/low phase of the blink line, declares lock after a run of good
// phases and latches a sticky fault. Define BLINK_MONITOR_SYNC_EN to synchronize the input.
module blink_monitor
  import blink_monitor_pkg::*;
#(
  parameter int HALF_PERIOD = DEF_HALF_PERIOD,
  parameter int TOLERANCE   = DEF_TOLERANCE,
  parameter int LOCK_COUNT  = DEF_LOCK_COUNT,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 blinker,
  input  logic                 clear,
  output logic                 edge_pulse,
  output logic                 locked,
  output logic                 fault,
  output logic [CNT_WIDTH-1:0] last_phase,
  output logic [15:0]          edge_count
);

  localparam int RUN_W = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] MIN_LEN = CNT_WIDTH'(HALF_PERIOD - TOLERANCE);
  localparam logic [CNT_WIDTH-1:0] MAX_LEN = CNT_WIDTH'(HALF_PERIOD + TOLERANCE);
  localparam logic [RUN_W-1:0]     RUN_LAST = RUN_W'(LOCK_COUNT - 1);

  state_t               state;
  logic                 s;
  logic                 prev;
  logic                 transition;
  logic                 good;
  logic                 timeout;
  logic [CNT_WIDTH-1:0] phase_cnt;
  logic [CNT_WIDTH-1:0] phase_len;
  logic [RUN_W-1:0]     good_run;

`ifdef BLINK_MONITOR_SYNC_EN
  blink_sync u_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .raw     (blinker),
    .synced  (s)
  );
`else
  assign s = blinker;
`endif

  // Length of the phase ending now; a saturated counter reports all-ones.
  assign transition = (s != prev);
  assign phase_len  = (phase_cnt == CNT_MAX) ? CNT_MAX : phase_cnt + 1'b1;
  assign good       = (phase_len >= MIN_LEN) && (phase_len <= MAX_LEN);
  assign timeout    = !transition && (phase_cnt == MAX_LEN);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= SEARCH;
      prev       <= 1'b0;
      phase_cnt  <= '0;
      good_run   <= '0;
      edge_pulse <= 1'b0;
      locked     <= 1'b0;
      fault      <= 1'b0;
      last_phase <= '0;
      edge_count <= '0;
    end else begin
      prev <= s;
      if (clear) begin
        state      <= SEARCH;
        phase_cnt  <= '0;
        good_run   <= '0;
        edge_pulse <= 1'b0;
        locked     <= 1'b0;
        fault      <= 1'b0;
        last_phase <= '0;
        edge_count <= '0;
      end else begin
        edge_pulse <= transition;
        if (transition) begin
          phase_cnt <= '0;
          if (edge_count != 16'hFFFF) edge_count <= edge_count + 16'd1;
        end else if (phase_cnt != CNT_MAX) begin
          phase_cnt <= phase_cnt + 1'b1;
        end
        if (transition && state != SEARCH) last_phase <= phase_len;

        // The partial phase seen in SEARCH is never judged.
        case (state)
          SEARCH: begin
            if (transition) state <= MEASURE;
          end
          MEASURE: begin
            if (transition) begin
              if (!good) begin
                good_run <= '0;
              end else if (good_run == RUN_LAST) begin
                good_run <= '0;
                state    <= LOCKED;
                locked   <= 1'b1;
              end else begin
                good_run <= good_run + 1'b1;
              end
            end else if (timeout) begin
              good_run <= '0;
            end
          end
          LOCKED: begin
            if ((transition && !good) || timeout) begin
              state  <= FAULT;
              locked <= 1'b0;
              fault  <= 1'b1;
            end
          end
          FAULT: begin
            state <= FAULT;
          end
          default: state <= SEARCH;
        endcase
      end
    end
  end

endmodule
